m_bp_update_queue: RTL and testbench

- Update side of the 32-entry 2-bit bimodal predictor table.
- Records each prediction issued at fetch (table index plus predicted direction) in an in-order queue.
- When a branch resolves, pops the oldest entry, drives the table write port (w_wa, w_we, w_token) and flags a misprediction.
- On a misprediction, flushes all younger wrong-path entries.

---
 rtl/m_bp_update_queue_pkg.sv | 12 +
 rtl/m_bpq_ring.sv | 25 ++
 rtl/m_bp_update_queue.sv | 110 +++++++++++
 tb/tb_m_bp_update_queue.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_bp_update_queue_pkg.sv
// Shared definitions for the bimodal predictor update queue: table geometry
// and the bit layout of one queued prediction entry {idx, pred}.
package m_bp_update_queue_pkg;

  localparam int BP_IDX_W = 5;   // 32-entry predictor table
  localparam int BP_CNT_W = 2;   // 2-bit saturating counters in the table

  // Entry layout: idx at [IDX_W:1], predicted direction at [0]
  localparam int ENT_PRED_BIT = 0;
  localparam int ENT_IDX_LSB  = 1;

endpackage

// File: rtl/m_bpq_ring.sv
// Storage for in-flight predictions: DEPTH x (IDX_W+1) registers, one write
// port at the tail pointer and a combinational read at the head pointer.
module m_bpq_ring #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [IDX_W:0]   wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [IDX_W:0]   rd_data
);

  logic [DEPTH-1:0][IDX_W:0] mem;

  // Storage is deliberately not reset; validity is tracked by the parent's count
  always_ff @(posedge clock) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/m_bp_update_queue.sv
// Update side of the bimodal predictor: queues fetch predictions in order,
// pops on resolve, drives the table write port and flushes on mispredict.
// Optional BPQ_STATS_EN adds 16-bit saturating hit/miss counters.
module m_bp_update_queue
  import m_bp_update_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = BP_IDX_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             w_clock,
  input  logic             w_reset,
  input  logic             w_enq,
  input  logic [IDX_W-1:0] w_enq_idx,
  input  logic             w_enq_pred,
  output logic             w_full,
  output logic [CNT_W-1:0] w_count,
  input  logic             w_res_valid,
  input  logic             w_res_taken,
  output logic             w_we,
  output logic [IDX_W-1:0] w_wa,
  output logic             w_token,
  output logic             w_mispredict,
  output logic             w_underflow
`ifdef BPQ_STATS_EN
  ,
  output logic [15:0]      w_stat_hits,
  output logic [15:0]      w_stat_misses
`endif
);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [IDX_W:0]   head_ent;
  logic             head_pred;
  logic [IDX_W-1:0] head_idx;
  logic             deq, mis, enq_ok;

  assign head_pred = head_ent[ENT_PRED_BIT];
  assign head_idx  = head_ent[IDX_W:ENT_IDX_LSB];

  assign w_full  = (count == CNT_W'(DEPTH));
  assign w_count = count;

  assign deq    = w_res_valid && (count != '0);
  assign mis    = deq && (head_pred != w_res_taken);
  // A mispredict puts everything younger on the wrong path, including this cycle's fetch
  assign enq_ok = w_enq && (!w_full || deq) && !mis;

  m_bpq_ring #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ring (
    .clock  (w_clock),
    .we     (enq_ok),
    .wr_ptr (tail),
    .wr_data({w_enq_idx, w_enq_pred}),
    .rd_ptr (head),
    .rd_data(head_ent)
  );

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mis) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq)    head <= head + PTR_W'(1);
      if (enq_ok) tail <= tail + PTR_W'(1);
      case ({enq_ok, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      w_we         <= 1'b0;
      w_wa         <= '0;
      w_token      <= 1'b0;
      w_mispredict <= 1'b0;
      w_underflow  <= 1'b0;
    end else begin
      w_we         <= deq;
      w_mispredict <= mis;
      w_underflow  <= w_res_valid && (count == '0);
      if (deq) begin
        w_wa    <= head_idx;
        w_token <= w_res_taken;
      end
    end
  end

`ifdef BPQ_STATS_EN
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      w_stat_hits   <= '0;
      w_stat_misses <= '0;
    end else begin
      if (deq && !mis && (w_stat_hits != 16'hFFFF))  w_stat_hits   <= w_stat_hits + 16'd1;
      if (mis && (w_stat_misses != 16'hFFFF))        w_stat_misses <= w_stat_misses + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m_bp_update_queue.sv
// Directed self-checking bench for m_bp_update_queue (DEPTH=4, IDX_W=5);
// stats checks are compiled in when BPQ_STATS_EN is defined.
module tb_m_bp_update_queue;

  logic       w_clock = 1'b0;
  logic       w_reset;
  logic       w_enq;
  logic [4:0] w_enq_idx;
  logic       w_enq_pred;
  logic       w_full;
  logic [2:0] w_count;
  logic       w_res_valid;
  logic       w_res_taken;
  logic       w_we;
  logic [4:0] w_wa;
  logic       w_token;
  logic       w_mispredict;
  logic       w_underflow;
`ifdef BPQ_STATS_EN
  logic [15:0] w_stat_hits, w_stat_misses;
`endif

  int checks = 0;
  int errors = 0;

  always #5 w_clock = ~w_clock;

  m_bp_update_queue #(.DEPTH(4), .IDX_W(5)) dut (
    .w_clock     (w_clock),
    .w_reset     (w_reset),
    .w_enq       (w_enq),
    .w_enq_idx   (w_enq_idx),
    .w_enq_pred  (w_enq_pred),
    .w_full      (w_full),
    .w_count     (w_count),
    .w_res_valid (w_res_valid),
    .w_res_taken (w_res_taken),
    .w_we        (w_we),
    .w_wa        (w_wa),
    .w_token     (w_token),
    .w_mispredict(w_mispredict),
    .w_underflow (w_underflow)
`ifdef BPQ_STATS_EN
    ,
    .w_stat_hits  (w_stat_hits),
    .w_stat_misses(w_stat_misses)
`endif
  );

  task automatic tick();
    @(posedge w_clock);
    #1;
  endtask

  task automatic idle();
    w_enq = 1'b0; w_enq_idx = '0; w_enq_pred = 1'b0;
    w_res_valid = 1'b0; w_res_taken = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    w_reset = 1'b1;
    tick();
    w_reset = 1'b0;
    tick();
  endtask

  task automatic enq_only(input logic [4:0] idx, input logic pred);
    w_enq = 1'b1; w_enq_idx = idx; w_enq_pred = pred;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    w_reset = 1'b1;
    #2;
    checks++;
    if (w_count !== 3'd0 || w_full !== 1'b0 || w_we !== 1'b0 || w_mispredict !== 1'b0 || w_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d full=%b we=%b mis=%b uf=%b, want 0 0 0 0 0",
               w_count, w_full, w_we, w_mispredict, w_underflow);
    end
    tick();
    w_reset = 1'b0;
    tick();
    w_res_valid = 1'b1; w_res_taken = 1'b1;
    tick();
    idle();
    checks++;
    if (w_underflow !== 1'b1 || w_we !== 1'b0 || w_count !== 3'd0) begin
      errors++;
      $display("FAIL empty_resolve: uf=%b we=%b count=%0d, want 1 0 0", w_underflow, w_we, w_count);
    end
    tick();
    checks++;
    if (w_underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_pulse: uf=%b, want 0", w_underflow);
    end
  endtask

  task automatic test_correct();
    enq_only(5'd7, 1'b1);
    checks++;
    if (w_count !== 3'd1) begin
      errors++;
      $display("FAIL correct_enq_count: count=%0d, want 1", w_count);
    end
    w_res_valid = 1'b1; w_res_taken = 1'b1;
    tick();
    idle();
    checks++;
    if (w_we !== 1'b1 || w_wa !== 5'd7 || w_token !== 1'b1 || w_mispredict !== 1'b0 || w_count !== 3'd0) begin
      errors++;
      $display("FAIL correct_write: we=%b wa=%0d tok=%b mis=%b count=%0d, want 1 7 1 0 0",
               w_we, w_wa, w_token, w_mispredict, w_count);
    end
    tick();
    checks++;
    if (w_we !== 1'b0 || w_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL correct_we_pulse: we=%b mis=%b, want 0 0", w_we, w_mispredict);
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 1; i <= 4; i++) enq_only(5'(i), 1'b0);
    checks++;
    if (w_full !== 1'b1 || w_count !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d, want 1 4", w_full, w_count);
    end
    enq_only(5'd5, 1'b0);
    checks++;
    if (w_count !== 3'd4) begin
      errors++;
      $display("FAIL fill_drop: count=%0d, want 4", w_count);
    end
    for (int i = 1; i <= 4; i++) begin
      w_res_valid = 1'b1; w_res_taken = 1'b0;
      tick();
      idle();
      checks++;
      if (w_we !== 1'b1 || w_wa !== 5'(i) || w_token !== 1'b0 || w_mispredict !== 1'b0) begin
        errors++;
        $display("FAIL fill_drain_%0d: we=%b wa=%0d tok=%b mis=%b, want 1 %0d 0 0",
                 i, w_we, w_wa, w_token, w_mispredict, i);
      end
    end
    checks++;
    if (w_count !== 3'd0) begin
      errors++;
      $display("FAIL fill_empty: count=%0d, want 0", w_count);
    end
    enq_only(5'd9, 1'b1);
    w_res_valid = 1'b1; w_res_taken = 1'b1;
    tick();
    idle();
    checks++;
    if (w_we !== 1'b1 || w_wa !== 5'd9 || w_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL wrap_write: we=%b wa=%0d mis=%b, want 1 9 0", w_we, w_wa, w_mispredict);
    end
  endtask

  task automatic test_flush();
    enq_only(5'd3, 1'b1);
    enq_only(5'd5, 1'b0);
    enq_only(5'd6, 1'b0);
    w_res_valid = 1'b1; w_res_taken = 1'b0;
    w_enq = 1'b1; w_enq_idx = 5'd8; w_enq_pred = 1'b0;
    tick();
    idle();
    checks++;
    if (w_we !== 1'b1 || w_wa !== 5'd3 || w_token !== 1'b0 || w_mispredict !== 1'b1 || w_count !== 3'd0) begin
      errors++;
      $display("FAIL flush_write: we=%b wa=%0d tok=%b mis=%b count=%0d, want 1 3 0 1 0",
               w_we, w_wa, w_token, w_mispredict, w_count);
    end
    tick();
    checks++;
    if (w_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL flush_mis_pulse: mis=%b, want 0", w_mispredict);
    end
    w_res_valid = 1'b1;
    tick();
    idle();
    checks++;
    if (w_underflow !== 1'b1 || w_we !== 1'b0) begin
      errors++;
      $display("FAIL flush_underflow: uf=%b we=%b, want 1 0", w_underflow, w_we);
    end
    // single-entry mispredict still drops the same-cycle enqueue
    enq_only(5'd12, 1'b1);
    w_res_valid = 1'b1; w_res_taken = 1'b0;
    w_enq = 1'b1; w_enq_idx = 5'd13; w_enq_pred = 1'b1;
    tick();
    idle();
    checks++;
    if (w_wa !== 5'd12 || w_mispredict !== 1'b1 || w_count !== 3'd0) begin
      errors++;
      $display("FAIL flush_single: wa=%0d mis=%b count=%0d, want 12 1 0", w_wa, w_mispredict, w_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_idx [4];
    exp_idx[0] = 5'd12; exp_idx[1] = 5'd13; exp_idx[2] = 5'd14; exp_idx[3] = 5'd10;
    for (int i = 11; i <= 14; i++) enq_only(5'(i), 1'b1);
    w_res_valid = 1'b1; w_res_taken = 1'b1;
    w_enq = 1'b1; w_enq_idx = 5'd10; w_enq_pred = 1'b1;
    tick();
    idle();
    checks++;
    if (w_count !== 3'd4 || w_full !== 1'b1 || w_wa !== 5'd11 || w_we !== 1'b1 || w_mispredict !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: count=%0d full=%b wa=%0d we=%b mis=%b, want 4 1 11 1 0",
               w_count, w_full, w_wa, w_we, w_mispredict);
    end
    for (int i = 0; i < 4; i++) begin
      w_res_valid = 1'b1; w_res_taken = 1'b1;
      tick();
      idle();
      checks++;
      if (w_we !== 1'b1 || w_wa !== exp_idx[i]) begin
        errors++;
        $display("FAIL b2b_order_%0d: we=%b wa=%0d, want 1 %0d", i, w_we, w_wa, exp_idx[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    enq_only(5'd21, 1'b1);
    w_res_valid = 1'b1; w_res_taken = 1'b1;
    tick();
    idle();
    checks++;
    if (w_we !== 1'b1 || w_wa !== 5'd21) begin
      errors++;
      $display("FAIL areset_pre: we=%b wa=%0d, want 1 21", w_we, w_wa);
    end
    #1 w_reset = 1'b1;
    #1;
    checks++;
    if (w_we !== 1'b0 || w_wa !== 5'd0 || w_count !== 3'd0) begin
      errors++;
      $display("FAIL areset_now: we=%b wa=%0d count=%0d, want 0 0 0", w_we, w_wa, w_count);
    end
    tick();
    w_reset = 1'b0;
    tick();
  endtask

`ifdef BPQ_STATS_EN
  task automatic test_stats();
    logic [4:0] preds [5];
    logic [4:0] outs  [5];
    do_reset();
    preds[0] = 1; preds[1] = 0; preds[2] = 1; preds[3] = 1; preds[4] = 0;
    outs[0]  = 1; outs[1]  = 1; outs[2]  = 1; outs[3]  = 0; outs[4]  = 0;
    for (int i = 0; i < 5; i++) begin
      enq_only(5'(i), preds[i][0]);
      w_res_valid = 1'b1; w_res_taken = outs[i][0];
      tick();
      idle();
    end
    checks++;
    if (w_stat_hits !== 16'd3 || w_stat_misses !== 16'd2) begin
      errors++;
      $display("FAIL stats_count: hits=%0d misses=%0d, want 3 2", w_stat_hits, w_stat_misses);
    end
    enq_only(5'd2, 1'b0);
    w_res_valid = 1'b1; w_res_taken = 1'b0;
    tick();
    idle();
    #1 w_reset = 1'b1;
    #1;
    checks++;
    if (w_stat_hits !== 16'd0 || w_stat_misses !== 16'd0 || w_we !== 1'b0) begin
      errors++;
      $display("FAIL stats_areset: hits=%0d misses=%0d we=%b, want 0 0 0", w_stat_hits, w_stat_misses, w_we);
    end
    tick();
    w_reset = 1'b0;
    tick();
  endtask
`endif

  initial begin
    idle();
    w_reset = 1'b0;
    test_reset();
    test_correct();
    test_fill_wrap();
    test_flush();
    do_reset();
    test_back_to_back();
    test_async_reset();
`ifdef BPQ_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
